// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - LEGv8 EX/MEM pipeline register with NZCV flags (optional flag register: EX_MEM_NZCV_EN)
module ex_mem_reg #(
    parameter int WORD     = 64,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic [WORD-1:0]     ex_ALUOut,
    input  logic                ex_Zero,
    input  logic                ex_Negative,
    input  logic                ex_Overflow,
    input  logic                ex_Co,
    input  logic [WORD-1:0]     ex_WriteData,
    input  logic [WORD-1:0]     ex_BrTarget,
    input  logic [REG_ADDR-1:0] ex_Rd,
    input  logic [5:0]          ex_ctl,
    input  logic                ex_SetFlags,
    output logic                mem_valid,
    output logic [WORD-1:0]     mem_ALUOut,
    output logic                mem_Zero,
    output logic [WORD-1:0]     mem_WriteData,
    output logic [WORD-1:0]     mem_BrTarget,
    output logic [REG_ADDR-1:0] mem_Rd,
    output logic [5:0]          mem_ctl,
    output logic                mem_PCSrc,
    output logic [3:0]          NZCV
);

    // Bit positions inside ex_ctl / mem_ctl: {RegWrite,MemRead,MemWrite,MemtoReg,Branch,UncondBranch}
    localparam int CTL_UNCOND = 0;
    localparam int CTL_BRANCH = 1;

    // A load only happens when neither flush nor stall is active
    logic load;
    assign load = !flush && !stall;

    // Pipeline register: flush inserts a bubble (data fields kept), stall holds, otherwise capture EX.
    // Control is zeroed for invalid entries so they can never write memory or registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid     <= 1'b0;
            mem_ALUOut    <= '0;
            mem_Zero      <= 1'b0;
            mem_WriteData <= '0;
            mem_BrTarget  <= '0;
            mem_Rd        <= '0;
            mem_ctl       <= '0;
        end else if (flush) begin
            mem_valid <= 1'b0;
            mem_ctl   <= '0;
            mem_Zero  <= 1'b0;
        end else if (load) begin
            mem_valid     <= ex_valid;
            mem_ALUOut    <= ex_ALUOut;
            mem_Zero      <= ex_Zero;
            mem_WriteData <= ex_WriteData;
            mem_BrTarget  <= ex_BrTarget;
            mem_Rd        <= ex_Rd;
            mem_ctl       <= ex_valid ? ex_ctl : 6'b000000;
        end
    end

    // Branch resolution: unconditional branch, or CBZ-style branch when the registered Zero is set.
    // mem_valid gating keeps this low through reset and for bubbles.
    assign mem_PCSrc = mem_valid &
                       (mem_ctl[CTL_UNCOND] | (mem_ctl[CTL_BRANCH] & mem_Zero));

`ifdef EX_MEM_NZCV_EN
    // Architectural flag register: only a real flag-setting instruction on a load edge updates it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            NZCV <= 4'b0000;
        end else if (load && ex_valid && ex_SetFlags) begin
            NZCV <= {ex_Negative, ex_Zero, ex_Co, ex_Overflow};
        end
    end
`else
    // No flag register in this build; flag inputs are intentionally ignored
    logic unused_flag_inputs;
    assign unused_flag_inputs = &{1'b0, ex_SetFlags, ex_Negative, ex_Overflow, ex_Co};
    assign NZCV = 4'b0000;
`endif

endmodule
